// File: rtl/fft_addr_gen.sv
// fft_addr_gen: radix-2 in-place FFT butterfly address generator.
// Turns the control stage's pair_id/stage stream into butterfly read
// addresses and a twiddle ROM index. It delays the read addresses through a
// model of the butterfly pipeline to form write-back addresses, and pulses
// pipeline_clear once every pair of the stage has been written back.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   fft_active       control stage is in its FFT state
//   pair_id          current pair index from control
//   stage_counter    current stage s from control
//   rd_valid         one butterfly read issued this cycle
//   rd_addr_a/b      lower/upper operand addresses
//   tw_addr          twiddle ROM index
//   wr_valid         one butterfly result written back this cycle
//   wr_addr_a/b      write-back addresses (rd_* delayed by BF_LATENCY)
//   pipeline_clear   one-cycle pulse: current stage fully written back
module fft_addr_gen #(
    parameter int unsigned N             = 32,
    parameter int unsigned BF_LATENCY    = 4,
    parameter int unsigned ADDR_W        = $clog2(N),
    parameter int unsigned pair_id_width = $clog2(N / 2),
    parameter int unsigned stage_width   = $clog2($clog2(N))
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fft_active,
    input  logic [pair_id_width-1:0] pair_id,
    input  logic [stage_width-1:0]   stage_counter,
    output logic                     rd_valid,
    output logic [ADDR_W-1:0]        rd_addr_a,
    output logic [ADDR_W-1:0]        rd_addr_b,
    output logic [ADDR_W-2:0]        tw_addr,
    output logic                     wr_valid,
    output logic [ADDR_W-1:0]        wr_addr_a,
    output logic [ADDR_W-1:0]        wr_addr_b,
    output logic                     pipeline_clear
);

    localparam int unsigned LOG2N  = $clog2(N);
    localparam int unsigned TW_W   = ADDR_W - 1;
    localparam int unsigned HALF_N = N / 2;
    localparam int unsigned LAT    = BF_LATENCY;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] issued_cnt;
    logic [ADDR_W-1:0] cnt_n;
    logic              issue;
    logic              abort;

    // Butterfly pipeline model: valid bits plus address copies
    logic [LAT-1:0]    sr_v;
    logic [LAT-1:0]    nxt_v;
    logic [ADDR_W-1:0] sr_a [LAT];
    logic [ADDR_W-1:0] sr_b [LAT];

    // Address arithmetic on the sampled inputs
    logic [ADDR_W-1:0]      pid;
    logic [ADDR_W-1:0]      half;
    logic [ADDR_W-1:0]      mask;
    logic [ADDR_W-1:0]      addr_a;
    logic [ADDR_W-1:0]      addr_b;
    logic [stage_width-1:0] tw_sh;
    logic [TW_W-1:0]        tw_c;

    always_comb begin
        pid    = ADDR_W'(pair_id);
        half   = ADDR_W'(1) << stage_counter;
        mask   = half - ADDR_W'(1);
        // Insert a zero at bit s of the pair index
        addr_a = ((pid & ~mask) << 1) | (pid & mask);
        addr_b = addr_a + half;
        // LOG2N-1 always fits in stage_width bits
        tw_sh  = stage_width'(LOG2N - 1) - stage_counter;
        tw_c   = TW_W'((pid & mask) << tw_sh);
    end

    // Valid bits as they will look after this edge (shift in rd_valid)
    assign nxt_v = LAT'({sr_v, rd_valid});

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, issue and abort decisions
    always_comb begin
        state_n = state;
        cnt_n   = issued_cnt;
        issue   = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (fft_active) begin
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (!fft_active) begin
                    abort   = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if ((pid == issued_cnt) && (issued_cnt < ADDR_W'(HALF_N))) begin
                    issue = 1'b1;
                    cnt_n = issued_cnt + ADDR_W'(1);
                    if (issued_cnt == ADDR_W'(HALF_N - 1)) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!fft_active) begin
                    abort   = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (nxt_v == '0) begin
                    // Last wr_valid is on the bus now; clear follows it
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                cnt_n   = '0;
                state_n = fft_active ? ISSUE : IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Registered outputs, issue counter and butterfly delay line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued_cnt     <= '0;
            rd_valid       <= 1'b0;
            rd_addr_a      <= '0;
            rd_addr_b      <= '0;
            tw_addr        <= '0;
            pipeline_clear <= 1'b0;
            sr_v           <= '0;
            for (int i = 0; i < LAT; i++) begin
                sr_a[i] <= '0;
                sr_b[i] <= '0;
            end
        end else begin
            issued_cnt     <= cnt_n;
            rd_valid       <= issue;
            pipeline_clear <= (state_n == CLEAR);
            if (issue) begin
                rd_addr_a <= addr_a;
                rd_addr_b <= addr_b;
                tw_addr   <= tw_c;
            end
            sr_v    <= abort ? '0 : nxt_v;
            sr_a[0] <= rd_addr_a;
            sr_b[0] <= rd_addr_b;
            for (int i = 1; i < LAT; i++) begin
                sr_a[i] <= sr_a[i-1];
                sr_b[i] <= sr_b[i-1];
            end
        end
    end

    assign wr_valid  = sr_v[LAT-1];
    assign wr_addr_a = sr_a[LAT-1];
    assign wr_addr_b = sr_b[LAT-1];

endmodule

// File: tb/tb_fft_addr_gen.sv
// tb_fft_addr_gen: scoreboard bench for fft_addr_gen (N=32, BF_LATENCY=4).
// The driver pushes the expected read/write addresses for each pair it
// expects to be issued; a negedge monitor pops and compares whenever the
// DUT raises rd_valid, wr_valid or pipeline_clear.
module tb_fft_addr_gen;

    localparam int unsigned N   = 32;
    localparam int unsigned LAT = 4;
    localparam int unsigned AW  = 5;
    localparam int unsigned PW  = 4;
    localparam int unsigned SW  = 3;
    localparam int unsigned TW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          fft_active;
    logic [PW-1:0] pair_id;
    logic [SW-1:0] stage_counter;
    logic          rd_valid;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [TW-1:0] tw_addr;
    logic          wr_valid;
    logic [AW-1:0] wr_addr_a;
    logic [AW-1:0] wr_addr_b;
    logic          pipeline_clear;

    fft_addr_gen #(
        .N(N),
        .BF_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fft_active(fft_active),
        .pair_id(pair_id),
        .stage_counter(stage_counter),
        .rd_valid(rd_valid),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .tw_addr(tw_addr),
        .wr_valid(wr_valid),
        .wr_addr_a(wr_addr_a),
        .wr_addr_b(wr_addr_b),
        .pipeline_clear(pipeline_clear)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [TW-1:0] tw;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   clear_exp  = 0;
    bit   quiet      = 1'b0;
    bit   prev_wr    = 1'b0;

    function automatic void check(string name, int unsigned act, int unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Hand-derived per-stage form: a skips every other block of half pairs,
    // twiddle index is k*N/2^(s+1) with k the position within the block.
    function automatic exp_t model(int s, int p);
        exp_t e;
        int half;
        half = 1 << s;
        e.a  = AW'(p + half * (p / half));
        e.b  = AW'(p + half * (p / half) + half);
        e.tw = TW'((p % half) * (16 / half));
        return e;
    endfunction

    task automatic push(input exp_t e);
        rd_q.push_back(e);
        wr_q.push_back(e);
    endtask

    task automatic push_abt(input int a, input int b, input int tw);
        exp_t e;
        e.a  = AW'(a);
        e.b  = AW'(b);
        e.tw = TW'(tw);
        push(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rd_valid"}, rd_valid, 0);
        check({tag, " rd_addr_a"}, rd_addr_a, 0);
        check({tag, " rd_addr_b"}, rd_addr_b, 0);
        check({tag, " tw_addr"}, tw_addr, 0);
        check({tag, " wr_valid"}, wr_valid, 0);
        check({tag, " wr_addr_a"}, wr_addr_a, 0);
        check({tag, " wr_addr_b"}, wr_addr_b, 0);
        check({tag, " pipeline_clear"}, pipeline_clear, 0);
    endtask

    task automatic wait_clear();
        bit seen;
        int i;
        seen = 1'b0;
        i    = 0;
        while (!seen && i < 40) begin
            tick();
            seen = pipeline_clear;
            i++;
        end
        if (!seen) check("pipeline_clear timeout", pipeline_clear, 1);
    endtask

    // Current cycle is the IDLE or CLEAR cycle before the stage starts
    task automatic run_stage(input int s, input int hold_at);
        stage_counter = SW'(s);
        fft_active    = 1'b1;
        pair_id       = '0;
        tick();
        for (int p = 0; p < 16; p++) begin
            pair_id = PW'(p);
            push(model(s, p));
            tick();
            if (p == hold_at) repeat (2) tick();
        end
        clear_exp++;
        wait_clear();
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (rd_valid) begin
                if (quiet || rd_q.size() == 0) begin
                    check("rd_valid unexpected", rd_valid, 0);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_addr_a", rd_addr_a, e.a);
                    check("rd_addr_b", rd_addr_b, e.b);
                    check("tw_addr", tw_addr, e.tw);
                end
            end
            if (wr_valid) begin
                if (quiet || wr_q.size() == 0) begin
                    check("wr_valid unexpected", wr_valid, 0);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr_a", wr_addr_a, e.a);
                    check("wr_addr_b", wr_addr_b, e.b);
                end
            end
            if (pipeline_clear) begin
                check("pipeline_clear expected", pipeline_clear, (clear_exp > 0 && !quiet) ? 1 : 0);
                check("pipeline_clear after last wr", prev_wr, 1);
                check("pipeline_clear wr drained", wr_q.size(), 0);
                if (clear_exp > 0) clear_exp--;
            end
            prev_wr = wr_valid;
        end else begin
            prev_wr = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        fft_active    = 1'b0;
        pair_id       = '0;
        stage_counter = '0;
        repeat (3) tick();
        check_all_zero("reset");

        @(negedge clk);
        reset = 1'b0;

        // Full stages back to back, straight through CLEAR
        run_stage(3, -1);
        run_stage(0, -1);
        // Pair 2 held for three cycles must issue only once
        run_stage(4, 2);

        // Abort after six issues in stage 1 (hand-computed addresses)
        stage_counter = SW'(1);
        pair_id       = '0;
        tick();
        push_abt(0, 2, 0);  pair_id = PW'(0); tick();
        push_abt(1, 3, 8);  pair_id = PW'(1); tick();
        push_abt(4, 6, 0);  pair_id = PW'(2); tick();
        push_abt(5, 7, 8);  pair_id = PW'(3); tick();
        push_abt(8, 10, 0); pair_id = PW'(4); tick();
        push_abt(9, 11, 8); pair_id = PW'(5); tick();
        fft_active = 1'b0;
        pair_id    = PW'(6);
        tick();
        // Only pairs 0 and 1 reached write-back before the abort edge
        check("abort dropped writes", wr_q.size(), 4);
        check("abort rd_valid", rd_valid, 0);
        check("abort wr_valid", wr_valid, 0);
        rd_q.delete();
        wr_q.delete();
        quiet = 1'b1;
        repeat (12) tick();
        quiet = 1'b0;

        // Stage 2 from IDLE, then async reset while draining
        stage_counter = SW'(2);
        fft_active    = 1'b1;
        pair_id       = '0;
        tick();
        for (int p = 0; p < 16; p++) begin
            pair_id = PW'(p);
            push(model(2, p));
            tick();
        end
        repeat (2) tick();
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("reset in drain");
        rd_q.delete();
        wr_q.delete();
        @(negedge clk);
        reset         = 1'b0;
        fft_active    = 1'b1;
        stage_counter = SW'(2);
        pair_id       = '0;
        tick();
        check("rd_valid first edge after reset", rd_valid, 0);
        push(model(2, 0));
        tick();
        check("rd_valid second edge after reset", rd_valid, 1);
        for (int p = 1; p < 16; p++) begin
            pair_id = PW'(p);
            push(model(2, p));
            tick();
        end
        clear_exp++;
        wait_clear();

        fft_active = 1'b0;
        repeat (4) tick();
        check("pending pipeline_clear", clear_exp, 0);
        check("pending reads", rd_q.size(), 0);
        check("pending writes", wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
